// File: rtl/draw_scheduler_pkg.sv
// Shared screen geometry, bus widths and FSM state encoding for the draw scheduler.
package draw_scheduler_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SCAN  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;
endpackage

// File: rtl/draw_scheduler_if.sv
// Client request bundle, sprite ROM port and VGA write port of the draw scheduler.
interface draw_scheduler_if
    import draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*8-1:0]        rect_x;
    logic [NUM_REQ*7-1:0]        rect_y;
    logic [NUM_REQ*8-1:0]        rect_w;
    logic [NUM_REQ*7-1:0]        rect_h;
    logic [NUM_REQ-1:0]          use_rom;
    logic [NUM_REQ*COLOUR_W-1:0] fill_colour;
    logic [NUM_REQ*ADDR_W-1:0]   rom_base;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          done;
    logic                        busy;
    logic [ADDR_W-1:0]           rom_addr;
    logic [COLOUR_W-1:0]         rom_data;
    logic [7:0]                  vga_x;
    logic [6:0]                  vga_y;
    logic [COLOUR_W-1:0]         vga_colour;
    logic                        vga_plot;

    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, use_rom, fill_colour, rom_base, rom_data,
        input  grant, done, busy, rom_addr, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, use_rom, fill_colour, rom_base, rom_data,
        output grant, done, busy, rom_addr, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PW-1:0]      idx_o
);
    always_comb begin
        int   k;
        logic found;
        k     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = PW'(k);
            end
        end
    end
endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates NUM_REQ rectangle-drawing clients onto one VGA write port, one pixel per clock,
// either solid fill or sprite ROM copy, with off-screen pixels suppressed.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic              clk,
    input logic              resetn,
    draw_scheduler_if.slave  bus
);
    localparam int PW = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d, owner_q, owner_d, win_idx;
    logic [NUM_REQ-1:0]   grant_q, grant_d, win_gnt;
    logic [7:0]           rx_q, rx_d, rw_q, rw_d, col_q, col_d, vx_q, vx_d;
    logic [6:0]           ry_q, ry_d, rh_q, rh_d, row_q, row_d, vy_q, vy_d;
    logic [COLOUR_W-1:0]  fill_q, fill_d, colour_q, colour_d;
    logic                 use_rom_q, use_rom_d, rom_pix_q, rom_pix_d, plot_q, plot_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [8:0]           px;
    logic [7:0]           py;
    logic                 last_col, last_pix, empty, pix_vis;
    int                   wsel;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx)
    );

    assign wsel     = int'(win_idx);
    assign px       = {1'b0, rx_q} + {1'b0, col_q};
    assign py       = {1'b0, ry_q} + {1'b0, row_q};
    assign pix_vis  = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    assign last_col = (col_q == rw_q - 8'd1);
    assign last_pix = last_col && (row_q == rh_q - 7'd1);
    assign empty    = (rw_q == 8'd0) || (rh_q == 7'd0);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        rw_d      = rw_q;
        rh_d      = rh_q;
        fill_d    = fill_q;
        use_rom_d = use_rom_q;
        addr_d    = addr_q;
        col_d     = col_q;
        row_d     = row_q;
        // Output stage: the pixel scanned this cycle is presented next cycle.
        plot_d    = (state_q == S_SCAN) && pix_vis;
        rom_pix_d = (state_q == S_SCAN) && use_rom_q;
        vx_d      = px[7:0];
        vy_d      = py[6:0];
        colour_d  = fill_q;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d   = S_LOAD;
                    owner_d   = win_idx;
                    grant_d   = win_gnt;
                    rx_d      = bus.rect_x[wsel*8 +: 8];
                    ry_d      = bus.rect_y[wsel*7 +: 7];
                    rw_d      = bus.rect_w[wsel*8 +: 8];
                    rh_d      = bus.rect_h[wsel*7 +: 7];
                    fill_d    = bus.fill_colour[wsel*COLOUR_W +: COLOUR_W];
                    use_rom_d = bus.use_rom[wsel];
                    addr_d    = bus.rom_base[wsel*ADDR_W +: ADDR_W];
                    col_d     = 8'd0;
                    row_d     = 7'd0;
                end
            end
            S_LOAD: state_d = empty ? S_DRAIN : S_SCAN;
            S_SCAN: begin
                addr_d = addr_q + ADDR_W'(1);
                if (last_col) begin
                    col_d = 8'd0;
                    row_d = row_q + 7'd1;
                end else begin
                    col_d = col_q + 8'd1;
                end
                if (last_pix) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            plot_q    <= 1'b0;
            rom_pix_q <= 1'b0;
            vx_q      <= '0;
            vy_q      <= '0;
            colour_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            plot_q    <= plot_d;
            rom_pix_q <= rom_pix_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            colour_q  <= colour_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_q      <= rx_d;
        ry_q      <= ry_d;
        rw_q      <= rw_d;
        rh_q      <= rh_d;
        fill_q    <= fill_d;
        use_rom_q <= use_rom_d;
        col_q     <= col_d;
        row_q     <= row_d;
    end

    // ROM data arrives one cycle after its address, aligned with the registered plot.
    assign bus.vga_colour = rom_pix_q ? bus.rom_data : colour_q;
    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = vx_q;
    assign bus.vga_y      = vy_q;
    assign bus.rom_addr   = addr_q;
    assign bus.grant      = grant_q;
    assign bus.done       = (state_q == S_DRAIN) ? grant_q : '0;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: fill, sprite, clipping, contention, empty rects, reset abort.
module tb_draw_scheduler;
    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    draw_scheduler_if #(.NUM_REQ(4)) bus ();

    draw_scheduler #(.NUM_REQ(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Sprite ROM model: registered read returning the low three address bits.
    always @(posedge clk) bus.rom_data <= bus.rom_addr[2:0];

    int          cyc;
    int          done_cyc;
    logic [3:0]  done_val;
    int          plot_x[$];
    int          plot_y[$];
    int          plot_c[$];
    int          plot_t[$];
    logic [14:0] addr_log[0:63];
    logic [3:0]  grant_log[0:63];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_client(input int i, input int x, input int y, input int w, input int h,
                              input logic rom, input int col, input int base);
        bus.rect_x[i*8 +: 8]      = 8'(x);
        bus.rect_y[i*7 +: 7]      = 7'(y);
        bus.rect_w[i*8 +: 8]      = 8'(w);
        bus.rect_h[i*7 +: 7]      = 7'(h);
        bus.use_rom[i]            = rom;
        bus.fill_colour[i*3 +: 3] = 3'(col);
        bus.rom_base[i*15 +: 15]  = 15'(base);
    endtask

    // Caller has set req in the current cycle (cycle 0); steps until a done pulse or the budget.
    task automatic run(input string tag, input int maxc, input logic release_req);
        cyc      = 0;
        done_cyc = -1;
        done_val = '0;
        plot_x.delete(); plot_y.delete(); plot_c.delete(); plot_t.delete();
        while (done_cyc < 0 && cyc < maxc) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc < 64) begin
                addr_log[cyc]  = bus.rom_addr;
                grant_log[cyc] = bus.grant;
            end
            if (bus.vga_plot) begin
                plot_x.push_back(int'(bus.vga_x));
                plot_y.push_back(int'(bus.vga_y));
                plot_c.push_back(int'(bus.vga_colour));
                plot_t.push_back(cyc);
            end
            if (bus.done != '0) begin
                done_cyc = cyc;
                done_val = bus.done;
                if (release_req) bus.req = bus.req & ~bus.done;
            end
        end
        check({tag, "_done_seen"}, (done_cyc >= 0), 1);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int ex1_x[6] = '{10, 11, 12, 10, 11, 12};
        int ex1_y[6] = '{5, 5, 5, 6, 6, 6};
        int ex2_c[8] = '{4, 5, 6, 7, 0, 1, 2, 3};
        int ex4_g[5] = '{1, 2, 4, 8, 1};

        resetn = 1'b0;
        bus.req = '0; bus.rect_x = '0; bus.rect_y = '0; bus.rect_w = '0; bus.rect_h = '0;
        bus.use_rom = '0; bus.fill_colour = '0; bus.rom_base = '0;
        step(); step();
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_plot", bus.vga_plot, 0);
        check("rst_done", bus.done, 0);
        check("rst_addr", bus.rom_addr, 0);
        resetn = 1'b1;
        step();

        // Solid fill from client 0
        set_client(0, 10, 5, 3, 2, 1'b0, 4, 0);
        bus.req = 4'b0001;
        run("fill", 40, 1'b1);
        check("fill_grant_load", grant_log[1], 4'b0001);
        check("fill_nplots", plot_x.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < plot_x.size()) begin
                check("fill_x", plot_x[i], ex1_x[i]);
                check("fill_y", plot_y[i], ex1_y[i]);
                check("fill_col", plot_c[i], 4);
                check("fill_t", plot_t[i], 3 + i);
            end
        end
        check("fill_done_cyc", done_cyc, 8);
        check("fill_done_val", done_val, 4'b0001);
        step();
        check("fill_busy_after", bus.busy, 0);
        check("fill_grant_after", bus.grant, 0);

        // Sprite copy from client 1
        set_client(1, 20, 30, 4, 2, 1'b1, 0, 100);
        bus.req = 4'b0010;
        run("sprite", 40, 1'b1);
        for (int i = 0; i < 8; i++) check("sprite_addr", addr_log[2 + i], 100 + i);
        check("sprite_nplots", plot_c.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < plot_c.size()) begin
                check("sprite_col", plot_c[i], ex2_c[i]);
                check("sprite_t", plot_t[i], 3 + i);
            end
        end
        check("sprite_done_cyc", done_cyc, 10);
        check("sprite_done_val", done_val, 4'b0010);
        step();

        // Clipping at the bottom-right corner
        set_client(2, 158, 119, 4, 3, 1'b0, 2, 0);
        bus.req = 4'b0100;
        run("clip", 40, 1'b1);
        check("clip_nplots", plot_x.size(), 2);
        if (plot_x.size() >= 2) begin
            check("clip_x0", plot_x[0], 158);
            check("clip_y0", plot_y[0], 119);
            check("clip_x1", plot_x[1], 159);
            check("clip_y1", plot_y[1], 119);
        end
        check("clip_done_cyc", done_cyc, 14);
        step();

        // Contention: all four hold req, pointer starts at 0 after reset
        resetn = 1'b0; step(); resetn = 1'b1;
        for (int i = 0; i < 4; i++) set_client(i, 10 * i, 1, 1, 1, 1'b0, i + 1, 0);
        bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            run("rr", 20, 1'b0);
            check("rr_grant", done_val, ex4_g[r]);
            check("rr_nplots", plot_x.size(), 1);
            check("rr_done_cyc", done_cyc, (r == 0) ? 3 : 4);
        end
        bus.req = '0;
        step(); step();

        // Empty rectangles: zero width, then zero height
        set_client(3, 5, 5, 0, 5, 1'b0, 7, 0);
        bus.req = 4'b1000;
        run("empty_w", 20, 1'b1);
        check("empty_w_done_cyc", done_cyc, 2);
        check("empty_w_done_val", done_val, 4'b1000);
        check("empty_w_nplots", plot_x.size(), 0);
        step(); step();
        set_client(3, 5, 5, 5, 0, 1'b0, 7, 0);
        bus.req = 4'b1000;
        run("empty_h", 20, 1'b1);
        check("empty_h_done_cyc", done_cyc, 2);
        check("empty_h_nplots", plot_x.size(), 0);
        step(); step();

        // Reset in the middle of a 10x10 fill at pixel 37
        set_client(3, 0, 0, 10, 10, 1'b0, 5, 0);
        bus.req = 4'b1000;
        for (int i = 0; i < 39; i++) step();
        check("abort_addr", bus.rom_addr, 37);
        check("abort_plot_before", bus.vga_plot, 1);
        resetn = 1'b0;
        step();
        check("abort_plot", bus.vga_plot, 0);
        check("abort_grant", bus.grant, 0);
        check("abort_done", bus.done, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_addr_rst", bus.rom_addr, 0);
        check("abort_x", bus.vga_x, 0);
        resetn = 1'b1;
        set_client(1, 1, 1, 1, 1, 1'b0, 3, 0);
        set_client(2, 2, 2, 1, 1, 1'b0, 3, 0);
        bus.req = 4'b0110;
        run("restart", 20, 1'b1);
        check("restart_grant", done_val, 4'b0010);
        check("restart_done_cyc", done_cyc, 3);
        bus.req = '0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
